instr_mem_loader: RTL
=====================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-002 SHALL have parameter INIT_WORD, default 0 (DATA_W bits), reset value of every memory entry.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port load_start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port load_origin  input  5  first write address, sampled with load_start.
REQ-007 SHALL have port load_len  input  6  word count, sampled with load_start; legal range 1..32.
REQ-008 SHALL have port load_abort  input  1  terminate an in-progress load.
REQ-009 SHALL have port s_valid  input  1  instruction word available.
REQ-010 SHALL have port s_data  input  DATA_W  instruction word.
REQ-011 SHALL have port s_ready  output  1  loader accepts a word this cycle.
REQ-012 SHALL have port rd_addr  input  5  read address, driven by the state machine program counter.
REQ-013 SHALL have port rd_data  output  DATA_W  instruction at rd_addr.
REQ-014 SHALL have port busy  output  1  high while in LOAD.
REQ-015 SHALL have port done  output  1  one-cycle pulse on completion.
REQ-016 SHALL have port err  output  1  sticky flag for an illegal load_len.
REQ-017 SHALL have port wr_count  output  6  words written in the current or last load.

Function
REQ-018 SHALL hold 32 entries of DATA_W bits, addressed modulo 32.
REQ-019 SHALL implement states IDLE, LOAD and DONE.
REQ-020 In IDLE, load_start with load_len in 1..32 SHALL do all of the following on the next cycle: enter LOAD, set wr_ptr=load_origin, set remaining=load_len, and clear wr_count to 0.
REQ-021 In IDLE, load_start with load_len=0 or load_len>32 SHALL set err=1, stay in IDLE, and leave memory untouched.
REQ-022 err SHALL clear only on reset or on a subsequent legal load_start.
REQ-023 load_start SHALL be ignored in LOAD and in DONE.
REQ-024 s_ready SHALL be 1 exactly when the state is LOAD; it SHALL be registered state, not combinationally dependent on s_valid.
REQ-025 A transfer SHALL occur on a cycle with s_valid && s_ready.
REQ-026 On each transfer: mem[wr_ptr] <= s_data; wr_ptr <= wr_ptr+1 mod 32 (31 wraps to 0); remaining decrements by 1; wr_count increments by 1.
REQ-027 A transfer with remaining==1 SHALL move the state to DONE on the next cycle.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 s_valid while not in LOAD SHALL be ignored, with no write.
REQ-030 In LOAD, load_abort SHALL return the state to IDLE next cycle with no done pulse; a transfer in the same cycle SHALL still be written and counted; entries already written SHALL be retained.
REQ-031 load_abort outside LOAD SHALL have no effect.
REQ-032 rd_data SHALL equal mem[rd_addr] combinationally.
REQ-033 A write and a read to the same address in one cycle SHALL return the old word that cycle and the new word from the next cycle.
REQ-034 A load of 32 words SHALL overwrite every entry exactly once regardless of origin.
REQ-035 busy SHALL equal (state==LOAD); done SHALL equal (state==DONE).

Reset
REQ-036 Asserting reset_n=0 SHALL immediately force IDLE, s_ready=0, busy=0, done=0, err=0, wr_count=0, wr_ptr=0, remaining=0, and every memory entry=INIT_WORD.
REQ-037 Reset during LOAD SHALL discard the load; no write SHALL occur on the clock edge coincident with or following an asserted reset_n.
REQ-038 Release of reset_n SHALL take effect on the first rising clk edge after deassertion, with the state in IDLE.

Verification
REQ-039 Scenario: origin=4, len=3, words A1,A2,A3 back-to-back -> mem[4..6]=A1..A3, wr_count=3, done pulses for one cycle, s_ready drops.
REQ-040 Scenario: origin=30, len=4 -> writes land at 30,31,0,1; mem[2] is unchanged.
REQ-041 Scenario: len=0, then len=40 -> err=1, state stays IDLE, memory unchanged; a following legal load clears err.
REQ-042 Scenario: s_valid toggling 1,0,0,1,1 with len=3 -> exactly 3 writes, done on the cycle after the third transfer.
REQ-043 Scenario: abort after 2 of 5 words, with a transfer in the abort cycle -> 3 entries written, wr_count=3, no done pulse.
REQ-044 Scenario: rd_addr=5 while word 0x1234 is written to entry 5 -> rd_data shows the old value that cycle and 0x1234 the next; reset_n pulsed mid-load -> all entries return to INIT_WORD.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: streams words from a valid/ready source into a
// 32-entry register-file memory starting at a sampled origin, with wrap and abort.
module instr_mem_loader #(
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic [4:0]        load_origin,
    input  logic [5:0]        load_len,
    input  logic              load_abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [5:0]        wr_count
);

    // state | meaning
    // IDLE  | waiting for a legal load_start
    // LOAD  | accepting words from the stream
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_wr_ptr;
    logic [5:0]        r_remaining;
    logic [5:0]        r_wr_count;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [32];

    logic w_len_legal;
    logic w_xfer;
    logic w_start_ok;
    logic w_start_bad;

    assign w_len_legal = (load_len != 6'd0) && (load_len <= 6'd32);
    assign w_xfer      = s_valid && (r_state == ST_LOAD);
    assign w_start_ok  = (r_state == ST_IDLE) && load_start && w_len_legal;
    assign w_start_bad = (r_state == ST_IDLE) && load_start && !w_len_legal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort takes priority over completion so an aborted load never pulses done.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_xfer && (r_remaining == 6'd1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= 5'd0;
            r_remaining <= 6'd0;
            r_wr_count  <= 6'd0;
            r_err       <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_wr_ptr    <= load_origin;
                r_remaining <= load_len;
                r_wr_count  <= 6'd0;
                r_err       <= 1'b0;
            end else if (w_start_bad) begin
                r_err <= 1'b1;
            end else if (w_xfer) begin
                r_wr_ptr    <= r_wr_ptr + 5'd1;
                r_remaining <= r_remaining - 6'd1;
                r_wr_count  <= r_wr_count + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= INIT_WORD;
            end
        end else if (w_xfer) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    assign rd_data  = r_mem[rd_addr];
    assign s_ready  = (r_state == ST_LOAD);
    assign busy     = (r_state == ST_LOAD);
    assign done     = (r_state == ST_DONE);
    assign err      = r_err;
    assign wr_count = r_wr_count;

endmodule
